// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------------------------
// instr_fetch_unit
//
// Initiator side of the instruction-memory path. Reads a 16-bit instruction as two consecutive
// bytes starting at PC (low byte first), assembles it, and presents it to the decode stage
// under a valid/ready handshake. Owns the program counter, which advances by one for every
// byte fetched and can be loaded for jumps.
//
// Ports
//   CLK      in   1          clock, all state updates on the rising edge
//   RST_N    in   1          asynchronous active-low reset
//   Start    in   1          fetch request (level), sampled in IDLE and HOLD
//   PCLoad   in   1          load PC from PCIn; aborts any fetch in progress
//   PCIn     in   ADDR_W     jump target for PCLoad
//   MemAddr  out  ADDR_W     memory read address (always the current PC)
//   MemRd    out  1          memory read request, high while reading either byte
//   MemAck   in   1          MemData is valid this cycle
//   MemData  in   DATA_W     memory read data
//   IRout    out  2*DATA_W   assembled instruction {byte@PC+1, byte@PC}
//   IRValid  out  1          IRout holds a complete instruction
//   IRReady  in   1          decoder takes IRout this cycle
//   PCOut    out  ADDR_W     current PC
//   Busy     out  1          fetch in progress (reading either byte)
// ---------------------------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                Start,
    input  logic                PCLoad,
    input  logic [ADDR_W-1:0]   PCIn,
    output logic [ADDR_W-1:0]   MemAddr,
    output logic                MemRd,
    input  logic                MemAck,
    input  logic [DATA_W-1:0]   MemData,
    output logic [2*DATA_W-1:0] IRout,
    output logic                IRValid,
    input  logic                IRReady,
    output logic [ADDR_W-1:0]   PCOut,
    output logic                Busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RD_LO = 2'd1;
    localparam logic [1:0] RD_HI = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [2*DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]   pc_inc;

    // Modulo 2^ADDR_W: a fetch starting at the top address wraps to zero for its high byte.
    assign pc_inc = pc_q + ADDR_W'(1);

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;

        if (PCLoad) begin
            // A jump wins over everything: any byte arriving this cycle is dropped without
            // advancing PC, Start is not looked at, and a held instruction is treated as
            // consumed. The fetch FSM restarts from IDLE at the new PC.
            pc_d    = PCIn;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_d = RD_LO;
                    end
                end

                RD_LO: begin
                    if (MemAck) begin
                        ir_d[DATA_W-1:0] = MemData;
                        pc_d             = pc_inc;
                        state_d          = RD_HI;
                    end
                end

                RD_HI: begin
                    if (MemAck) begin
                        ir_d[2*DATA_W-1:DATA_W] = MemData;
                        pc_d                    = pc_inc;
                        state_d                 = HOLD;
                    end
                end

                HOLD: begin
                    // IRout stays frozen until the decoder takes it; with Start still high
                    // the next fetch begins immediately (back-to-back).
                    if (IRReady) begin
                        state_d = Start ? RD_LO : IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs: all decoded straight from registered state so that an asynchronous reset is
    // visible on every output without waiting for a clock edge.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        MemAddr = pc_q;
        PCOut   = pc_q;
        IRout   = ir_q;
        MemRd   = (state_q == RD_LO) || (state_q == RD_HI);
        Busy    = MemRd;
        IRValid = (state_q == HOLD);
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. A byte-wide memory model answers reads with a
// programmable number of wait cycles. A cycle-by-cycle vector table covers the basic fetch,
// HOLD back-pressure, back-to-back fetch and PCLoad behaviour; hand-written sequences cover
// wait states, PC wrap, PCLoad during RD_HI and asynchronous reset mid-fetch.
// ---------------------------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        CLK;
    logic        RST_N;
    logic        Start;
    logic        PCLoad;
    logic [7:0]  PCIn;
    logic [7:0]  MemAddr;
    logic        MemRd;
    logic        MemAck;
    logic [7:0]  MemData;
    logic [15:0] IRout;
    logic        IRValid;
    logic        IRReady;
    logic [7:0]  PCOut;
    logic        Busy;

    int total;
    int bad;

    instr_fetch_unit #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .RESET_PC (8'h00)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .Start   (Start),
        .PCLoad  (PCLoad),
        .PCIn    (PCIn),
        .MemAddr (MemAddr),
        .MemRd   (MemRd),
        .MemAck  (MemAck),
        .MemData (MemData),
        .IRout   (IRout),
        .IRValid (IRValid),
        .IRReady (IRReady),
        .PCOut   (PCOut),
        .Busy    (Busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory model: acknowledges a read after ack_wait idle cycles; ack_force injects a
    // stray acknowledge regardless of MemRd.
    logic [7:0] mem [256];
    int         ack_wait;
    logic       ack_force;
    int         wait_cnt;

    assign MemData = mem[MemAddr];
    assign MemAck  = (MemRd && (wait_cnt >= ack_wait)) || ack_force;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt <= 0;
        end else if (!MemRd || MemAck) begin
            wait_cnt <= 0;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock edge and settle before sampling.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N     = 1'b0;
        Start     = 1'b0;
        PCLoad    = 1'b0;
        PCIn      = 8'h00;
        IRReady   = 1'b0;
        ack_force = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    typedef struct {
        logic        start;
        logic        pcload;
        logic [7:0]  pcin;
        logic        irready;
        logic        ackf;
        logic        memrd;
        logic        irvalid;
        logic [7:0]  pc;
        logic        chk_ir;
        logic [15:0] ir;
    } vec_t;

    function automatic vec_t mk(input logic start, input logic pcload, input logic [7:0] pcin,
                                input logic irready, input logic ackf, input logic memrd,
                                input logic irvalid, input logic [7:0] pc, input logic chk_ir,
                                input logic [15:0] ir);
        vec_t v;
        v.start   = start;
        v.pcload  = pcload;
        v.pcin    = pcin;
        v.irready = irready;
        v.ackf    = ackf;
        v.memrd   = memrd;
        v.irvalid = irvalid;
        v.pc      = pc;
        v.chk_ir  = chk_ir;
        v.ir      = ir;
        return v;
    endfunction

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    initial begin
        int edges;
        total = 0;
        bad   = 0;

        for (int i = 0; i < 256; i++) mem[i] = ~i[7:0];
        mem[8'h00] = 8'h34;
        mem[8'h01] = 8'h12;
        mem[8'h02] = 8'h78;
        mem[8'h03] = 8'h56;
        mem[8'hFF] = 8'hCD;

        //             st pl pcin   rdy af  rd vl pc     ci ir
        vecs[0]  = mk(1, 0, 8'h00, 0, 0,  1, 0, 8'h00, 1, 16'h0000); // IDLE -> RD_LO
        vecs[1]  = mk(0, 0, 8'h00, 0, 0,  1, 0, 8'h01, 1, 16'h0034); // low byte
        vecs[2]  = mk(0, 0, 8'h00, 0, 0,  0, 1, 8'h02, 1, 16'h1234); // HOLD
        vecs[3]  = mk(0, 0, 8'h00, 0, 0,  0, 1, 8'h02, 1, 16'h1234); // back-pressure x4
        vecs[4]  = mk(0, 0, 8'h00, 0, 1,  0, 1, 8'h02, 1, 16'h1234); // stray ack in HOLD
        vecs[5]  = mk(0, 0, 8'h00, 0, 0,  0, 1, 8'h02, 1, 16'h1234);
        vecs[6]  = mk(0, 0, 8'h00, 0, 0,  0, 1, 8'h02, 1, 16'h1234);
        vecs[7]  = mk(1, 0, 8'h00, 1, 0,  1, 0, 8'h02, 1, 16'h1234); // back-to-back
        vecs[8]  = mk(0, 0, 8'h00, 0, 0,  1, 0, 8'h03, 1, 16'h1278);
        vecs[9]  = mk(0, 0, 8'h00, 0, 0,  0, 1, 8'h04, 1, 16'h5678);
        vecs[10] = mk(1, 1, 8'h10, 1, 0,  0, 0, 8'h10, 1, 16'h5678); // PCLoad in HOLD
        vecs[11] = mk(0, 0, 8'h00, 1, 1,  0, 0, 8'h10, 1, 16'h5678); // IDLE ignores ack/ready
        vecs[12] = mk(1, 0, 8'h00, 0, 0,  1, 0, 8'h10, 1, 16'h5678);
        vecs[13] = mk(0, 1, 8'h20, 0, 0,  0, 0, 8'h20, 0, 16'h0000); // PCLoad in RD_LO + ack
        vecs[14] = mk(0, 0, 8'h00, 0, 0,  0, 0, 8'h20, 0, 16'h0000);

        // ---------------- reset state ----------------
        ack_wait = 0;
        do_reset();
        check("reset_memrd", MemRd, 0);
        check("reset_irvalid", IRValid, 0);
        check("reset_busy", Busy, 0);
        check("reset_pc", PCOut, 8'h00);
        check("reset_irout", IRout, 16'h0000);

        // ---------------- table vectors (zero-wait memory) ----------------
        for (int i = 0; i < NVEC; i++) begin
            Start     = vecs[i].start;
            PCLoad    = vecs[i].pcload;
            PCIn      = vecs[i].pcin;
            IRReady   = vecs[i].irready;
            ack_force = vecs[i].ackf;
            step();
            ack_force = 1'b0;
            check($sformatf("v%0d_memrd", i), MemRd, vecs[i].memrd);
            check($sformatf("v%0d_busy", i), Busy, vecs[i].memrd);
            check($sformatf("v%0d_irvalid", i), IRValid, vecs[i].irvalid);
            check($sformatf("v%0d_pc", i), PCOut, vecs[i].pc);
            check($sformatf("v%0d_memaddr", i), MemAddr, vecs[i].pc);
            if (vecs[i].chk_ir) check($sformatf("v%0d_irout", i), IRout, vecs[i].ir);
        end
        Start   = 1'b0;
        PCLoad  = 1'b0;
        IRReady = 1'b0;

        // ---------------- jump to FF, fetch spans the wrap ----------------
        mem[8'h00] = 8'hAB;
        PCLoad = 1'b1;
        PCIn   = 8'hFF;
        step();
        PCLoad = 1'b0;
        check("wrap_load_pc", PCOut, 8'hFF);
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        check("wrap_mid_pc", PCOut, 8'h00);
        check("wrap_mid_addr", MemAddr, 8'h00);
        step();
        check("wrap_irvalid", IRValid, 1);
        check("wrap_irout", IRout, 16'hABCD);
        check("wrap_pc", PCOut, 8'h01);
        IRReady = 1'b1;
        step();
        IRReady = 1'b0;
        check("wrap_release", IRValid, 0);

        // ---------------- two wait cycles per byte ----------------
        mem[8'h00] = 8'h34;
        ack_wait   = 2;
        do_reset();
        Start = 1'b1;
        edges = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            edges++;
            Start = 1'b0;
            if (IRValid) break;
            check($sformatf("wait_memrd_e%0d", edges), MemRd, 1);
            check($sformatf("wait_addr_e%0d", edges), MemAddr, (edges <= 3) ? 8'h00 : 8'h01);
        end
        check("wait_latency_edges", edges, 7);
        check("wait_irvalid", IRValid, 1);
        check("wait_irout", IRout, 16'h1234);
        check("wait_pc", PCOut, 8'h02);
        ack_wait = 0;

        // ---------------- PCLoad in RD_HI with same-cycle ack ----------------
        do_reset();
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        check("ld_hi_pre_pc", PCOut, 8'h01);
        PCLoad = 1'b1;
        PCIn   = 8'h40;
        step();
        PCLoad = 1'b0;
        check("ld_hi_memrd", MemRd, 0);
        check("ld_hi_irvalid", IRValid, 0);
        check("ld_hi_busy", Busy, 0);
        check("ld_hi_pc", PCOut, 8'h40);
        step();
        check("ld_hi_idle_memrd", MemRd, 0);
        check("ld_hi_idle_pc", PCOut, 8'h40);

        // ---------------- async reset mid RD_HI ----------------
        do_reset();
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        check("arst_pre_memrd", MemRd, 1);
        check("arst_pre_pc", PCOut, 8'h01);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("arst_memrd", MemRd, 0);
        check("arst_irvalid", IRValid, 0);
        check("arst_busy", Busy, 0);
        check("arst_pc", PCOut, 8'h00);
        check("arst_irout", IRout, 16'h0000);
        #1;
        RST_N = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("arst_idle%0d_memrd", c), MemRd, 0);
            check($sformatf("arst_idle%0d_pc", c), PCOut, 8'h00);
        end
        Start = 1'b1;
        step();
        Start = 1'b0;
        check("arst_restart_memrd", MemRd, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
